mips_rst_seq: RTL and testbench

Synthesizable reset sequencer and run monitor for the multi-core MIPS pipeline harness. It turns one asynchronous board reset into N_CH staggered, synchronously released, active-high channel resets, one per core or subsystem. It then counts run cycles until the core signals halt or a watchdog expires. A software reset request restarts the whole sequence without toggling the board reset.

---
 rtl/mips_harness_pkg.sv | 19 +
 rtl/rst_sync2.sv | 29 ++
 rtl/mips_rst_seq.sv | 153 +++++++++++++++
 tb/tb_mips_rst_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_harness_pkg.sv
// mips_harness_pkg
//   Shared types and helpers for the MIPS pipeline harness blocks.
//   - state_e   : reset-sequencer state encoding (3 bits)
//   - cnt_width : counter width needed to hold values 0..max_val (min 1)
package mips_harness_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync2.sv
// rst_sync2
//   Two-flop reset synchronizer: asserts asynchronously, releases on the
//   second rising clock edge after rst_ni goes high.
//   Ports:
//     clk_i  : destination clock
//     rst_ni : asynchronous active-low reset
//     rel_o  : 1 once reset release has been synchronized into clk_i
module rst_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rel_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

    assign rel_o = sync2_q;

endmodule

// File: rtl/mips_rst_seq.sv
// mips_rst_seq
//   Reset sequencer and run monitor. Turns the board reset into N_CH
//   staggered active-high channel resets, then counts RUN cycles until halt
//   or watchdog expiry. sw_rst_req restarts the sequence without the
//   synchronizer latency.
//   Ports:
//     clk          : system clock, rising edge
//     reset        : asynchronous active-low board reset
//     sw_rst_req   : synchronous software restart request
//     halt         : core finished (honoured only in RUN)
//     ch_rst       : per-channel reset, active-high
//     all_released : every channel released (RUN / HALTED)
//     run_cycles   : saturating count of RUN cycles
//     done         : halt observed
//     timeout      : watchdog expired
//     state_dbg_o  : current FSM state (debug visibility)
module mips_rst_seq
    import mips_harness_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 32,
    parameter int WDT_CYCLES  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_rst_req,
    input  logic             halt,
    output logic [N_CH-1:0]  ch_rst,
    output logic             all_released,
    output logic [CNT_W-1:0] run_cycles,
    output logic             done,
    output logic             timeout,
    output logic [2:0]       state_dbg_o
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int STAG_W = cnt_width((N_CH - 1) * STAGGER);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'((N_CH - 1) * STAGGER);
    localparam logic [CNT_W-1:0]  RUN_MAX   = '1;
    localparam logic [CNT_W-1:0]  WDT_LAST  = CNT_W'(WDT_CYCLES - 1);

    state_e            state_q;
    logic [N_CH-1:0]   ch_rst_q;
    logic              all_rel_q;
    logic [CNT_W-1:0]  run_q;
    logic              done_q;
    logic              timeout_q;
    logic [HOLD_W-1:0] hold_q;
    logic [STAG_W-1:0] stag_q;

    logic              sync_rel;
    logic [STAG_W-1:0] stag_d;
    logic [CNT_W-1:0]  run_d;

    rst_sync2 u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .rel_o  (sync_rel)
    );

    // stag_d is the number of edges since entering RELEASE, counting this one.
    assign stag_d = stag_q + STAG_W'(1);
    assign run_d  = (run_q == RUN_MAX) ? run_q : run_q + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ASSERT;
            ch_rst_q  <= '1;
            all_rel_q <= 1'b0;
            run_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            stag_q    <= '0;
        end else if (sw_rst_req) begin
            // Synchronizer is left alone, so hold counting resumes next edge.
            state_q   <= ST_ASSERT;
            ch_rst_q  <= '1;
            all_rel_q <= 1'b0;
            run_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            stag_q    <= '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (sync_rel) begin
                        if (hold_q == HOLD_LAST) begin
                            ch_rst_q[0] <= 1'b0;
                            hold_q      <= '0;
                            stag_q      <= '0;
                            if (N_CH == 1) begin
                                state_q   <= ST_RUN;
                                all_rel_q <= 1'b1;
                            end else begin
                                state_q <= ST_RELEASE;
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    stag_q <= stag_d;
                    for (int i = 1; i < N_CH; i++) begin
                        if (stag_d == STAG_W'(i * STAGGER)) begin
                            ch_rst_q[i] <= 1'b0;
                        end
                    end
                    if (stag_d == STAG_LAST) begin
                        state_q   <= ST_RUN;
                        all_rel_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // halt wins over a coincident watchdog expiry.
                    if (halt) begin
                        state_q <= ST_HALTED;
                        done_q  <= 1'b1;
                    end else begin
                        run_q <= run_d;
                        if ((WDT_CYCLES != 0) && (run_q == WDT_LAST)) begin
                            state_q   <= ST_TIMEOUT;
                            timeout_q <= 1'b1;
                            ch_rst_q  <= '1;
                            all_rel_q <= 1'b0;
                        end
                    end
                end
                ST_HALTED, ST_TIMEOUT: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q  <= ST_ASSERT;
                    ch_rst_q <= '1;
                end
            endcase
        end
    end

    assign ch_rst       = ch_rst_q;
    assign all_released = all_rel_q;
    assign run_cycles   = run_q;
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_mips_rst_seq.sv
// tb_mips_rst_seq
//   Three sequencer configurations (defaults, watchdog=8, single small
//   channel) share clock and board reset; each has its own halt and
//   software reset. Expected outputs come from a timing model: channel i
//   is released at edge rel0 + i*STAGGER, where rel0 is derived from the
//   edge that started the sequence.
module tb_mips_rst_seq;

    localparam int P_N    [3] = '{4, 4, 1};
    localparam int P_HOLD [3] = '{10, 10, 1};
    localparam int P_ST   [3] = '{2, 2, 2};
    localparam int P_CW   [3] = '{32, 32, 4};
    localparam int P_WDT  [3] = '{0, 8, 0};

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic [2:0] sw;
    logic [2:0] hlt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic [3:0]  ch0, ch1;
    logic        ch2;
    logic [31:0] rc0, rc1;
    logic [3:0]  rc2;
    logic        ar0, ar1, ar2, dn0, dn1, dn2, to0, to1, to2;
    logic [2:0]  st0, st1, st2;

    mips_rst_seq u_def (
        .clk(clk), .reset(reset), .sw_rst_req(sw[0]), .halt(hlt[0]),
        .ch_rst(ch0), .all_released(ar0), .run_cycles(rc0),
        .done(dn0), .timeout(to0), .state_dbg_o(st0)
    );

    mips_rst_seq #(.WDT_CYCLES(8)) u_wdt (
        .clk(clk), .reset(reset), .sw_rst_req(sw[1]), .halt(hlt[1]),
        .ch_rst(ch1), .all_released(ar1), .run_cycles(rc1),
        .done(dn1), .timeout(to1), .state_dbg_o(st1)
    );

    mips_rst_seq #(.N_CH(1), .CNT_W(4), .HOLD_CYCLES(1)) u_small (
        .clk(clk), .reset(reset), .sw_rst_req(sw[2]), .halt(hlt[2]),
        .ch_rst(ch2), .all_released(ar2), .run_cycles(rc2),
        .done(dn2), .timeout(to2), .state_dbg_o(st2)
    );

    // ---------------- reference model ----------------
    // ph: 0 = sequencing, 1 = run, 2 = halted, 3 = timed out
    int     e;
    int     rel0 [3];
    int     ph   [3];
    longint runm [3];
    bit     dnm  [3];
    bit     tom  [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int k = 0; k < 3; k++) begin
            rel0[k] = P_HOLD[k] + 2;
            ph[k]   = 0;
            runm[k] = 0;
            dnm[k]  = 1'b0;
            tom[k]  = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        longint maxv;
        int a, b;
        maxv = (64'd1 << P_CW[k]) - 1;
        if (sw[k]) begin
            // Hold counting needs the synchronizer, which is live from edge 3.
            a = e + P_HOLD[k];
            b = P_HOLD[k] + 2;
            rel0[k] = (a > b) ? a : b;
            ph[k]   = 0;
            runm[k] = 0;
            dnm[k]  = 1'b0;
            tom[k]  = 1'b0;
        end else if (ph[k] == 0) begin
            if (e >= rel0[k] + (P_N[k] - 1) * P_ST[k]) ph[k] = 1;
        end else if (ph[k] == 1) begin
            if (hlt[k]) begin
                ph[k]  = 2;
                dnm[k] = 1'b1;
            end else begin
                if (P_WDT[k] != 0 && runm[k] == P_WDT[k] - 1) begin
                    ph[k]  = 3;
                    tom[k] = 1'b1;
                end
                if (runm[k] < maxv) runm[k]++;
            end
        end
    endtask

    task automatic check_inst(input int k);
        logic [63:0] och, oar, orc, odn, oto, ost, ech, est;
        case (k)
            0: begin och = 64'(ch0); oar = 64'(ar0); orc = 64'(rc0); odn = 64'(dn0); oto = 64'(to0); ost = 64'(st0); end
            1: begin och = 64'(ch1); oar = 64'(ar1); orc = 64'(rc1); odn = 64'(dn1); oto = 64'(to1); ost = 64'(st1); end
            default: begin och = 64'(ch2); oar = 64'(ar2); orc = 64'(rc2); odn = 64'(dn2); oto = 64'(to2); ost = 64'(st2); end
        endcase
        ech = '0;
        for (int i = 0; i < P_N[k]; i++) begin
            if (ph[k] == 0)      ech[i] = (e < rel0[k] + i * P_ST[k]);
            else if (ph[k] == 3) ech[i] = 1'b1;
        end
        case (ph[k])
            0:       est = (e < rel0[k]) ? 64'd0 : 64'd1;
            1:       est = 64'd2;
            2:       est = 64'd3;
            default: est = 64'd4;
        endcase
        chk($sformatf("i%0d_ch_rst e=%0d", k, e), och, ech);
        chk($sformatf("i%0d_all_released e=%0d", k, e), oar, 64'(ph[k] == 1 || ph[k] == 2));
        chk($sformatf("i%0d_run_cycles e=%0d", k, e), orc, 64'(runm[k]));
        chk($sformatf("i%0d_done e=%0d", k, e), odn, 64'(dnm[k]));
        chk($sformatf("i%0d_timeout e=%0d", k, e), oto, 64'(tom[k]));
        chk($sformatf("i%0d_state e=%0d", k, e), ost, est);
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) check_inst(k);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model follows the edge, outputs are checked at the negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            e++;
            for (int k = 0; k < 3; k++) model_step(k);
        end
        @(negedge clk);
        check_all();
    endtask

    // Pull reset low between edges and check outputs before any clock.
    task automatic async_reset(input int low_cycles);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_ch_rst", 64'(ch0), 64'hF);
        chk("async_state", 64'(st0), 64'd0);
        @(negedge clk);
        for (int i = 0; i < low_cycles; i++) tick();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s2;
        reset = 1'b1;
        sw    = '0;
        hlt   = '0;
        model_reset();
        #1;
        reset = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;

        // Board release sequence.
        for (int i = 0; i < 20; i++) begin
            tick();
            if (e == 11) chk("def_ch_e11", 64'(ch0), 64'hF);
            if (e == 12) chk("def_ch_e12", 64'(ch0), 64'hE);
            if (e == 14) chk("def_ch_e14", 64'(ch0), 64'hC);
            if (e == 16) chk("def_ch_e16", 64'(ch0), 64'h8);
            if (e == 18) chk("def_ch_e18", 64'(ch0), 64'h0);
            if (e == 18) chk("def_all_rel_e18", 64'(ar0), 64'd1);
            if (e == 3)  chk("small_run_e3", 64'(st2), 64'd2);
        end

        // 25 RUN cycles, then halt.
        while (e < 43) tick();
        hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        chk("def_halt_run", 64'(rc0), 64'd25);
        chk("def_halt_done", 64'(dn0), 64'd1);
        for (int i = 0; i < 3; i++) tick();
        hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        tick();
        chk("def_halt2_run", 64'(rc0), 64'd25);
        chk("def_halt2_state", 64'(st0), 64'd3);
        chk("wdt_timeout", 64'(to1), 64'd1);
        chk("wdt_ch_rst", 64'(ch1), 64'hF);
        chk("wdt_run", 64'(rc1), 64'd8);
        chk("small_sat", 64'(rc2), 64'd15);

        // Software restart of everything.
        sw = 3'b111;
        tick();
        sw = '0;

        // Restart the default instance again during RELEASE (ch_rst=1100).
        n = 0;
        while (e < rel0[0] + 2 && n < 50) begin tick(); n++; end
        chk("wait_release", 64'(n < 50), 64'd1);
        chk("def_ch_1100", 64'(ch0), 64'hC);
        sw[0] = 1'b1;
        tick();
        sw[0] = 1'b0;
        s2 = e;
        chk("def_sw_ch", 64'(ch0), 64'hF);
        chk("def_sw_run", 64'(rc0), 64'd0);
        chk("def_sw_done", 64'(dn0), 64'd0);
        while (e < s2 + 10) tick();
        chk("def_sw_ch0_rel", 64'(ch0), 64'hE);

        // Halt coinciding with the watchdog edge.
        n = 0;
        while (!(ph[1] == 1 && runm[1] == 7) && n < 100) begin tick(); n++; end
        chk("wait_wdt_edge", 64'(n < 100), 64'd1);
        hlt[1] = 1'b1;
        tick();
        hlt[1] = 1'b0;
        chk("wdt_halt_done", 64'(dn1), 64'd1);
        chk("wdt_halt_timeout", 64'(to1), 64'd0);

        // Async reset mid-RUN.
        n = 0;
        while (ph[0] != 1 && n < 100) begin tick(); n++; end
        chk("wait_run", 64'(n < 100), 64'd1);
        async_reset(2);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (e == 18) chk("rerel_ch_e18", 64'(ch0), 64'h0);
        end

        // Randomized phase.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                hlt[k] = ($urandom_range(0, 15) == 0);
                sw[k]  = ($urandom_range(0, 59) == 0);
            end
            tick();
            if ($urandom_range(0, 299) == 0) begin
                sw  = '0;
                hlt = '0;
                async_reset($urandom_range(1, 3));
            end
        end
        sw  = '0;
        hlt = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
